// File: rtl/nibble_add_sequencer.sv
// Multi-precision adder front end: walks WIDTH-bit operands through an external
// 4-bit adder core one nibble per cycle, LS nibble first, chaining the carry.
module nibble_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [3:0]       a_nib, b_nib;
  logic             last;

  assign last = (idx == IW'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Handshake outputs stay quiet for the whole reset assertion, not just after the edge.
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
    end
  end

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IW'(n)) begin
        a_nib = a_reg[n*4 +: 4];
        b_nib = b_reg[n*4 +: 4];
      end
    end
  end

  // Core inputs are forced to zero outside RUN so the core sees no stray activity.
  assign add_a   = (state == RUN && !rst) ? a_nib     : 4'h0;
  assign add_b   = (state == RUN && !rst) ? b_nib     : 4'h0;
  assign add_cin = (state == RUN && !rst) ? carry_reg : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= op_cin;
            idx       <= '0;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++)
            if (idx == IW'(n)) sum[n*4 +: 4] <= add_sum;
          carry_reg <= add_cout;
          idx       <= idx + 1'b1;
          if (last) cout <= add_cout;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Randomized self-checking bench for nibble_add_sequencer with a behavioural
// 4-bit adder core and a 17-bit arithmetic reference.
module tb_nibble_add_sequencer;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_cin;
  logic [3:0]       add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, busy;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  int exp_xfers = 0;

  always #5 clk = ~clk;

  // Adder core model: plain 4-bit addition, combinational.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

  always @(posedge clk)
    if (!rst && out_valid && out_ready) xfers++;

  nibble_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction: accept, RUN walk, DONE hold, transfer.
  task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ci, input int hold, input bit noise, input bit rnd_rdy);
    logic [WIDTH:0]   ref_v;
    logic [WIDTH-1:0] s0;
    logic             c0;
    int               k, lo, exp_cin, exp_an, exp_bn;
    ref_v = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready: got %b want 1", in_ready);
    end
    in_valid = 1'b1; op_a = a; op_b = b; op_cin = ci;
    step();
    in_valid = noise;
    op_a = noise ? 16'hAAAA : WIDTH'($urandom);
    op_b = WIDTH'($urandom);
    op_cin = 1'($urandom);
    k = 0;
    while (!out_valid && k < 20) begin
      lo      = (1 << (4 * k)) - 1;
      exp_cin = ((int'(a) & lo) + (int'(b) & lo) + int'(ci)) >> (4 * k);
      exp_an  = (int'(a) >> (4 * k)) & 15;
      exp_bn  = (int'(b) >> (4 * k)) & 15;
      checks++;
      if (add_cin !== 1'(exp_cin) || add_a !== 4'(exp_an) || add_b !== 4'(exp_bn)) begin
        errors++;
        $display("FAIL core_in nib%0d: got a=%h b=%h cin=%b want a=%h b=%h cin=%b",
                 k, add_a, add_b, add_cin, exp_an, exp_bn, exp_cin);
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL run_flags: got in_ready=%b busy=%b want 0 1", in_ready, busy);
      end
      out_ready = rnd_rdy ? 1'($urandom) : 1'b0;
      step();
      k++;
    end
    checks++;
    if (k !== N) begin
      errors++; $display("FAIL latency: got %0d want %0d", k, N);
    end
    checks++;
    if (sum !== ref_v[WIDTH-1:0] || cout !== ref_v[WIDTH]) begin
      errors++;
      $display("FAIL result a=%h b=%h cin=%b: got sum=%h cout=%b want sum=%h cout=%b",
               a, b, ci, sum, cout, ref_v[WIDTH-1:0], ref_v[WIDTH]);
    end
    checks++;
    if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      errors++; $display("FAIL core_idle: got a=%h b=%h cin=%b want 0", add_a, add_b, add_cin);
    end
    s0 = sum; c0 = cout;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || sum !== s0 || cout !== c0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: got ov=%b sum=%h cout=%b ir=%b want 1 %h %b 0",
                 h, out_valid, sum, cout, in_ready, s0, c0);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    exp_xfers++;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_xfer: got ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b1; out_ready = 1'b0;
    step(); step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL in_reset: got ir=%b ov=%b busy=%b a=%h b=%h cin=%b want all 0",
               in_ready, out_valid, busy, add_a, add_b, add_cin);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || sum !== '0 || cout !== 1'b0) begin
      errors++; $display("FAIL reset_vals: got ir=%b sum=%h cout=%b want 1 0 0", in_ready, sum, cout);
    end
  endtask

  task automatic test_directed();
    run_add(16'h1234, 16'h4321, 1'b1, 0, 1'b0, 1'b0);  // sum 5556, cout 0
    run_add(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);  // carry ripples: cin 0,1,1,1
  endtask

  task automatic test_backpressure();
    run_add(16'h8001, 16'h8002, 1'b1, 5, 1'b0, 1'b1);
  endtask

  task automatic test_busy_ignore();
    run_add(16'h0F00, 16'h0123, 1'b0, 2, 1'b1, 1'b0);
  endtask

  task automatic test_reset_abort();
    in_valid = 1'b1; op_a = 16'h5555; op_b = 16'h3333; op_cin = 1'b0;
    step();
    in_valid = 1'b0;
    step();  // now in the 2nd RUN cycle
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_during: got ov=%b ir=%b busy=%b want 0 0 0", out_valid, in_ready, busy);
    end
    @(negedge clk);
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: got ov=%b ir=%b sum=%h cout=%b want 0 1 0 0", out_valid, in_ready, sum, cout);
    end
    @(negedge clk);
    run_add(16'h0F0F, 16'hF0F0, 1'b1, 0, 1'b0, 1'b0);  // sum 0000, cout 1
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++)
      run_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b1);
    checks++;
    if (xfers !== exp_xfers) begin
      errors++; $display("FAIL xfer_count: got %0d want %0d", xfers, exp_xfers);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    test_directed();
    test_backpressure();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
